// File: rtl/mult_accumulator.sv
// Sum-of-products accumulator fed by the 16x8 multiplier's 24-bit product.
// Build option: define MULT_ACC_SAT_EN to saturate instead of wrap on carry out.
module mult_accumulator #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic [23:0]      product,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic             beat;
    logic             take_start;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_add;

    assign beat       = (state == ACCUM) && prod_valid;
    assign take_start = (state == IDLE) && start;
    assign sum        = {1'b0, acc} + {{(ACC_W + 1 - 24){1'b0}}, product};

`ifdef MULT_ACC_SAT_EN
    // Once pinned at all ones, any nonzero add carries again, so it stays pinned.
    assign acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                prod_ready = 1'b1;
                busy       = 1'b1;
                if (beat && cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                busy      = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            ovf <= 1'b0;
        end else if (take_start) begin
            cnt <= len;
            acc <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            cnt <= cnt - CNT_W'(1);
            acc <= acc_add;
            ovf <= ovf | sum[ACC_W];
        end
    end

    assign result   = acc;
    assign overflow = ovf;

endmodule

// File: tb/tb_mult_accumulator.sv
// Directed bench for mult_accumulator: a 32-bit and a 24-bit instance
// run in lockstep on the same stimulus.
module tb_mult_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [23:0] product;
    logic        res_ready;

    logic        prod_ready;
    logic        res_valid;
    logic [31:0] result;
    logic        overflow;
    logic        busy;

    logic        prod_ready24;
    logic        res_valid24;
    logic [23:0] result24;
    logic        overflow24;
    logic        busy24;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_accumulator #(.ACC_W(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready),
        .product(product), .res_valid(res_valid),
        .res_ready(res_ready), .result(result),
        .overflow(overflow), .busy(busy)
    );

    mult_accumulator #(.ACC_W(24), .CNT_W(8)) dut24 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .prod_valid(prod_valid), .prod_ready(prod_ready24),
        .product(product), .res_valid(res_valid24),
        .res_ready(res_ready), .result(result24),
        .overflow(overflow24), .busy(busy24)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start      = 1'b0;
        len        = 8'd0;
        prod_valid = 1'b0;
        product    = 24'd0;
        res_ready  = 1'b0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_idle: busy=%b res_valid=%b want 0 0", busy, res_valid);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({prod_ready, res_valid, overflow, busy} !== 4'b0000 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_vals: pr=%b rv=%b ov=%b busy=%b res=%h want all 0",
                     prod_ready, res_valid, overflow, busy, result);
        end
    endtask

    task automatic test_basic_sum();
        start = 1'b1;
        len   = 8'd3;
        step();
        start = 1'b0;
        checks++;
        if (prod_ready !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_enter: pr=%b busy=%b want 1 1", prod_ready, busy);
        end
        prod_valid = 1'b1;
        product    = 24'hFEFF01;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (res_valid !== 1'b0 || prod_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_beat%0d: rv=%b pr=%b want 0 1", i, res_valid, prod_ready);
            end
            step();
        end
        prod_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || result !== 32'h02FCFD03 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: rv=%b res=%h ov=%b want 1 02fcfd03 0",
                     res_valid, result, overflow);
        end
        checks++;
        if (prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pr: pr=%b want 0", prod_ready);
        end
        drain();
    endtask

    task automatic test_bubbles();
        start = 1'b1;
        len   = 8'd2;
        step();
        start      = 1'b0;
        prod_valid = 1'b1;
        product    = 24'h000010;
        step();
        prod_valid = 1'b0;
        product    = 24'h0000FF;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (result !== 32'h10 || res_valid !== 1'b0 || prod_ready !== 1'b1) begin
                errors++;
                $display("FAIL bubble%0d: res=%h rv=%b pr=%b want 10 0 1",
                         i, result, res_valid, prod_ready);
            end
            step();
        end
        prod_valid = 1'b1;
        product    = 24'h000020;
        step();
        prod_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || result !== 32'h30) begin
            errors++;
            $display("FAIL bubble_result: rv=%b res=%h want 1 30", res_valid, result);
        end
        drain();
    endtask

    task automatic test_overflow();
        logic [23:0] exp24;
`ifdef MULT_ACC_SAT_EN
        exp24 = 24'hFFFFFF;
`else
        exp24 = 24'hFDFE02;
`endif
        start = 1'b1;
        len   = 8'd2;
        step();
        start      = 1'b0;
        prod_valid = 1'b1;
        product    = 24'hFEFF01;
        step();
        step();
        prod_valid = 1'b0;
        checks++;
        if (res_valid24 !== 1'b1 || result24 !== exp24 || overflow24 !== 1'b1) begin
            errors++;
            $display("FAIL ovf24: rv=%b res=%h ov=%b want 1 %h 1",
                     res_valid24, result24, overflow24, exp24);
        end
        checks++;
        if (result !== 32'h01FDFE02 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf32: res=%h ov=%b want 01fdfe02 0", result, overflow);
        end
        drain();
    endtask

    task automatic test_empty_backpressure();
        start = 1'b1;
        len   = 8'd0;
        step();
        checks++;
        if (res_valid !== 1'b1 || result !== 32'd0 || overflow24 !== 1'b0) begin
            errors++;
            $display("FAIL empty_result: rv=%b res=%h ov24=%b want 1 0 0",
                     res_valid, result, overflow24);
        end
        start      = 1'b1;
        len        = 8'd3;
        prod_valid = 1'b1;
        product    = 24'h123456;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (res_valid !== 1'b1 || result !== 32'd0 || prod_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: rv=%b res=%h pr=%b want 1 0 0",
                         i, res_valid, result, prod_ready);
            end
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || prod_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_release: busy=%b rv=%b pr=%b want 0 0 0",
                     busy, res_valid, prod_ready);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        len   = 8'd4;
        step();
        start      = 1'b0;
        prod_valid = 1'b1;
        product    = 24'h000007;
        step();
        start = 1'b1;
        len   = 8'd1;
        step();
        start = 1'b0;
        checks++;
        if (result !== 32'd14 || prod_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: res=%h pr=%b rv=%b want e 1 0",
                     result, prod_ready, res_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        checks++;
        if ({prod_ready, res_valid, overflow, busy} !== 4'b0000 || result !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: pr=%b rv=%b ov=%b busy=%b res=%h want all 0",
                     prod_ready, res_valid, overflow, busy, result);
        end
        start = 1'b1;
        len   = 8'd1;
        step();
        start      = 1'b0;
        prod_valid = 1'b1;
        product    = 24'h000005;
        step();
        prod_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || result !== 32'h5 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL after_reset: rv=%b res=%h ov=%b want 1 5 0",
                     res_valid, result, overflow);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_sum();
        test_bubbles();
        test_overflow();
        test_empty_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
